// File: rtl/if_id_stall_ctrl.sv
// IF/ID pipeline register with stall/flush control and a sticky stall watchdog.
// Optional STALL_STATS_EN adds stall_total_o, a saturating count of stalled cycles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | ID advances normally (loads IF or idles to NOP)
// ST_STALL | previous edge held IF/ID because of an effective hazard
// ST_FLUSH | previous edge squashed IF/ID; lasts one cycle
module if_id_stall_ctrl #(
  parameter int                  WORD      = 32,
  parameter int                  INST_LEN  = 32,
  parameter logic [INST_LEN-1:0] NOP_INST  = 32'h00000013,
  parameter int                  MAX_STALL = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INST_LEN-1:0] inst_if_i,
  input  logic [WORD-1:0]     pc_if_i,
  input  logic                if_valid_i,
  input  logic                hazard_i,
  input  logic                flush_i,
  output logic [INST_LEN-1:0] inst_id_o,
  output logic [WORD-1:0]     pc_id_o,
  output logic                valid_id_o,
  output logic                pc_write_o,
  output logic                bubble_o,
  output logic                stall_active_o,
  output logic                stall_timeout_o
`ifdef STALL_STATS_EN
  ,
  output logic [31:0]         stall_total_o
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int CNT_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MAX_STALL);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t              state_q, state_d;
  logic [INST_LEN-1:0] inst_id_q, inst_id_d;
  logic [WORD-1:0]     pc_id_q, pc_id_d;
  logic                valid_id_q, valid_id_d;
  logic [CNT_W-1:0]    stall_left_q, stall_left_d;
  logic                timeout_q, timeout_d;
  logic                stall_eff;

`ifdef STALL_STATS_EN
  logic [31:0]         stall_total_q, stall_total_d;
`endif

  // A hazard only matters when ID actually holds something worth keeping.
  assign stall_eff = hazard_i & valid_id_q & ~flush_i;

  always_comb begin
    state_d    = ST_RUN;
    inst_id_d  = inst_id_q;
    pc_id_d    = pc_id_q;
    valid_id_d = valid_id_q;

    if (flush_i) begin
      state_d    = ST_FLUSH;
      inst_id_d  = NOP_INST;
      pc_id_d    = pc_if_i;
      valid_id_d = 1'b0;
    end else if (stall_eff) begin
      state_d    = ST_STALL;
    end else if (if_valid_i) begin
      state_d    = ST_RUN;
      inst_id_d  = inst_if_i;
      pc_id_d    = pc_if_i;
      valid_id_d = 1'b1;
    end else begin
      state_d    = ST_RUN;
      inst_id_d  = NOP_INST;
      valid_id_d = 1'b0;
    end
  end

  // Watchdog counts down the remaining stall budget; terminal count is zero.
  always_comb begin
    stall_left_d = CNT_INIT;
    timeout_d    = timeout_q;
    if (stall_eff) begin
      stall_left_d = (stall_left_q != '0) ? (stall_left_q - CNT_ONE) : '0;
      if (stall_left_q == CNT_ONE) begin
        timeout_d = 1'b1;
      end
    end
  end

`ifdef STALL_STATS_EN
  always_comb begin
    stall_total_d = stall_total_q;
    if (stall_eff && (stall_total_q != 32'hFFFF_FFFF)) begin
      stall_total_d = stall_total_q + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      inst_id_q    <= NOP_INST;
      pc_id_q      <= '0;
      valid_id_q   <= 1'b0;
      stall_left_q <= CNT_INIT;
      timeout_q    <= 1'b0;
`ifdef STALL_STATS_EN
      stall_total_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      inst_id_q    <= inst_id_d;
      pc_id_q      <= pc_id_d;
      valid_id_q   <= valid_id_d;
      stall_left_q <= stall_left_d;
      timeout_q    <= timeout_d;
`ifdef STALL_STATS_EN
      stall_total_q <= stall_total_d;
`endif
    end
  end

  assign inst_id_o       = inst_id_q;
  assign pc_id_o         = pc_id_q;
  assign valid_id_o      = valid_id_q;
  assign pc_write_o      = ~stall_eff;
  assign bubble_o        = stall_eff;
  assign stall_active_o  = (state_q == ST_STALL);
  assign stall_timeout_o = timeout_q;
`ifdef STALL_STATS_EN
  assign stall_total_o   = stall_total_q;
`endif

endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// Scoreboard bench for if_id_stall_ctrl: a driver pushes expected outputs from a
// behavioural model, a monitor pops and compares on every falling edge.
module tb_if_id_stall_ctrl;

  localparam int          MAX_STALL = 4;
  localparam logic [31:0] NOP       = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_if_i, pc_if_i;
  logic        if_valid_i, hazard_i, flush_i;
  logic [31:0] inst_id_o, pc_id_o;
  logic        valid_id_o, pc_write_o, bubble_o, stall_active_o, stall_timeout_o;
`ifdef STALL_STATS_EN
  logic [31:0] stall_total_o;
`endif

  if_id_stall_ctrl #(.WORD(32), .INST_LEN(32), .NOP_INST(NOP), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_if_i(inst_if_i), .pc_if_i(pc_if_i), .if_valid_i(if_valid_i),
    .hazard_i(hazard_i), .flush_i(flush_i),
    .inst_id_o(inst_id_o), .pc_id_o(pc_id_o), .valid_id_o(valid_id_o),
    .pc_write_o(pc_write_o), .bubble_o(bubble_o),
    .stall_active_o(stall_active_o), .stall_timeout_o(stall_timeout_o)
`ifdef STALL_STATS_EN
    , .stall_total_o(stall_total_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
    logic        pc_write;
    logic        bubble;
    logic        active;
    logic        timeout;
    logic [31:0] total;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: what ID holds, how long the current stall run is, etc.
  logic [31:0] m_inst, m_pc;
  logic        m_valid, m_prev_stall, m_to;
  int          m_run;
  longint      m_total;

  task automatic model_reset();
    m_inst = NOP; m_pc = 0; m_valid = 0; m_prev_stall = 0;
    m_to = 0; m_run = 0; m_total = 0;
  endtask

  task automatic step(input bit rst, input bit hz, input bit fl, input bit ifv,
                      input logic [31:0] inst, input logic [31:0] pc);
    exp_t e;
    bit   eff;
    @(posedge clk);
    #1;
    rst_n = rst; hazard_i = hz; flush_i = fl; if_valid_i = ifv;
    inst_if_i = inst; pc_if_i = pc;
    if (!rst) model_reset();
    eff = hz && m_valid && !fl;
    e.inst = m_inst; e.pc = m_pc; e.valid = m_valid;
    e.pc_write = !eff; e.bubble = eff; e.active = m_prev_stall;
    e.timeout = m_to;
    e.total = (m_total > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_total[31:0];
    exp_q.push_back(e);
    if (rst) begin
      if (fl) begin
        m_inst = NOP; m_valid = 0; m_pc = pc;
      end else if (eff) begin
        // ID holds its contents
      end else if (ifv) begin
        m_inst = inst; m_pc = pc; m_valid = 1;
      end else begin
        m_inst = NOP; m_valid = 0;
      end
      m_run = eff ? m_run + 1 : 0;
      if (m_run >= MAX_STALL) m_to = 1;
      if (eff) m_total++;
      m_prev_stall = eff;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h want 0x%08h", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("inst_id",       inst_id_o,       e.inst);
        chk("pc_id",         pc_id_o,         e.pc);
        chk("valid_id",      {31'd0, valid_id_o},      {31'd0, e.valid});
        chk("pc_write",      {31'd0, pc_write_o},      {31'd0, e.pc_write});
        chk("bubble",        {31'd0, bubble_o},        {31'd0, e.bubble});
        chk("stall_active",  {31'd0, stall_active_o},  {31'd0, e.active});
        chk("stall_timeout", {31'd0, stall_timeout_o}, {31'd0, e.timeout});
`ifdef STALL_STATS_EN
        chk("stall_total",   stall_total_o,   e.total);
`endif
      end
    end
  end

  initial begin : driver
    int wait_cyc;
    rst_n = 0; hazard_i = 0; flush_i = 0; if_valid_i = 0;
    inst_if_i = 0; pc_if_i = 0;
    model_reset();

    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 32'h55, 32'h44);
    // Load first instruction, then a 3-cycle stall, then release.
    step(1, 0, 0, 1, 32'hA, 32'h100);
    step(1, 1, 0, 1, 32'hB, 32'h104);
    step(1, 1, 0, 1, 32'hB, 32'h104);
    step(1, 1, 0, 1, 32'hB, 32'h104);
    step(1, 0, 0, 1, 32'hB, 32'h104);
    step(1, 0, 0, 1, 32'hC, 32'h108);
    // Stall interrupted by flush with hazard still high.
    step(1, 1, 0, 1, 32'hD, 32'h10C);
    step(1, 1, 1, 1, 32'hD, 32'h200);
    step(1, 1, 0, 1, 32'hE, 32'h204);
    step(1, 0, 0, 1, 32'hE, 32'h204);
    // Long stall to trip the watchdog, then confirm it stays set.
    for (int i = 0; i < 6; i++) step(1, 1, 0, 1, 32'hF, 32'h208);
    step(1, 0, 0, 1, 32'h10, 32'h20C);
    step(1, 0, 0, 0, 32'h11, 32'h210);
    // Hazard against an empty ID is ignored.
    step(1, 1, 0, 0, 32'h12, 32'h214);
    step(1, 1, 0, 0, 32'h12, 32'h214);
    // Reset in the middle of a stall.
    step(1, 0, 0, 1, 32'h20, 32'h300);
    step(1, 1, 0, 1, 32'h21, 32'h304);
    step(1, 1, 0, 1, 32'h21, 32'h304);
    step(0, 1, 0, 1, 32'h21, 32'h304);
    step(1, 0, 0, 1, 32'h22, 32'h308);
    // Uninterrupted 5-cycle stall after reset.
    for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 32'h23, 32'h30C);
    step(1, 0, 0, 1, 32'h24, 32'h310);
    step(1, 0, 0, 0, 32'h25, 32'h314);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 8),
           ($urandom_range(0, 99) < 75),
           $urandom(), $urandom());
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
